// File: rtl/dcu_pkg.sv
// Shared DCU definitions: sequencer state encoding, header field layout,
// block mode constants and error codes.
package dcu_pkg;

    // Sequencer states, 3-bit encoding kept stable for legacy tooling
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_CL_RUN  = 3'd2;
    localparam logic [2:0] ST_DEC_RUN = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    // Header nibble layout; bit 2 is reserved and ignored
    localparam int unsigned HDR_FINAL_BIT = 3;
    localparam int unsigned HDR_MODE_MSB  = 1;
    localparam int unsigned HDR_MODE_LSB  = 0;

    // Block modes (2 and 3 are illegal)
    localparam logic [1:0] MODE_DYN   = 2'd0;
    localparam logic [1:0] MODE_REUSE = 2'd1;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MODE    = 2'd1;
    localparam logic [1:0] ERR_REUSE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Extract the mode field from a header nibble
    function automatic logic [1:0] hdr_mode(input logic [3:0] nib);
        return nib[HDR_MODE_MSB:HDR_MODE_LSB];
    endfunction

    // Extract the final-block flag from a header nibble
    function automatic logic hdr_final(input logic [3:0] nib);
        return nib[HDR_FINAL_BIT];
    endfunction

    // States in which a stream is in progress
    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == ST_HDR) || (st == ST_CL_RUN) || (st == ST_DEC_RUN);
    endfunction

    // States in which a consumer owns the FIFO and the watchdog is armed
    function automatic logic is_run_state(input logic [2:0] st);
        return (st == ST_CL_RUN) || (st == ST_DEC_RUN);
    endfunction

endpackage

// File: rtl/dcu_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT-th consecutive stall cycle occurs.
module dcu_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic enb,
    output logic expired
);

    localparam int unsigned    CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Stall counter; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (enb) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Expiry fires on the stall cycle that would bring the count to TIMEOUT
    always_comb begin
        expired = enb && !clr && (cnt == LAST);
    end

endmodule

// File: rtl/dcu_seq.sv
// DCU block sequencer: owns the input FIFO read port, pops block headers and
// hands the FIFO alternately to the code-length extractor and the decoder.
module dcu_seq
    import dcu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned BLKW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            rempty,
    input  logic [3:0]      rdata,
    output logic            fifo_rinc,
    output logic            cl_rst_n,
    output logic            cl_enb,
    output logic            cl_rempty,
    input  logic            cl_rinc,
    input  logic            cl_fin,
    output logic            tree_load,
    output logic            dec_enb,
    output logic            dec_rempty,
    input  logic            dec_rinc,
    input  logic            dec_eob,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [BLKW-1:0] blk_cnt
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] err_code_nxt;
    logic       final_r;
    logic       trees_valid;

    logic       run_cl;
    logic       run_dec;
    logic       hdr_pop;
    logic       start_acc;
    logic       cl_done;
    logic       dec_done;

    logic       wd_clr;
    logic       wd_enb;
    logic       wd_expired;

    // FIFO ownership and consumer gating, decoded purely from state
    always_comb begin
        run_cl     = (state == ST_CL_RUN);
        run_dec    = (state == ST_DEC_RUN);
        hdr_pop    = (state == ST_HDR) && !rempty;
        start_acc  = start && !is_busy_state(state);
        cl_done    = run_cl && cl_fin;
        dec_done   = run_dec && dec_eob;

        cl_enb     = run_cl;
        dec_enb    = run_dec;
        cl_rempty  = run_cl  ? rempty : 1'b1;
        dec_rempty = run_dec ? rempty : 1'b1;

        // Pops are additionally gated by rempty so a misbehaving consumer
        // can never underflow the FIFO
        fifo_rinc  = !rempty && ((state == ST_HDR)
                              || (run_cl  && cl_rinc)
                              || (run_dec && dec_rinc));
    end

    // Watchdog only sees stalls while a consumer has data it is not taking.
    // Clearing outside run states makes every state change restart the
    // count without feeding next-state back into the watchdog.
    always_comb begin
        wd_enb = is_run_state(state) && !rempty && !fifo_rinc;
        wd_clr = !is_run_state(state) || fifo_rinc || cl_done || dec_done;
    end

    dcu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .enb     (wd_enb),
        .expired (wd_expired)
    );

    // Next-state and error-code decode; completion events beat a timeout
    always_comb begin
        state_nxt    = state;
        err_code_nxt = err_code;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt    = ST_HDR;
                    err_code_nxt = ERR_NONE;
                end
            end
            ST_HDR: begin
                if (!rempty) begin
                    case (hdr_mode(rdata))
                        MODE_DYN: begin
                            state_nxt = ST_CL_RUN;
                        end
                        MODE_REUSE: begin
                            if (trees_valid) begin
                                state_nxt = ST_DEC_RUN;
                            end else begin
                                state_nxt    = ST_ERR;
                                err_code_nxt = ERR_REUSE;
                            end
                        end
                        default: begin
                            state_nxt    = ST_ERR;
                            err_code_nxt = ERR_MODE;
                        end
                    endcase
                end
            end
            ST_CL_RUN: begin
                if (cl_fin) begin
                    state_nxt = ST_DEC_RUN;
                end else if (wd_expired) begin
                    state_nxt    = ST_ERR;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_DEC_RUN: begin
                if (dec_eob) begin
                    state_nxt = final_r ? ST_DONE : ST_HDR;
                end else if (wd_expired) begin
                    state_nxt    = ST_ERR;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered status/control outputs derived from the
    // next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            cl_rst_n  <= 1'b0;
            tree_load <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= is_busy_state(state_nxt);
            done      <= (state_nxt == ST_DONE);
            err       <= (state_nxt == ST_ERR);
            err_code  <= err_code_nxt;
            cl_rst_n  <= (state_nxt == ST_CL_RUN);
            tree_load <= cl_done;
        end
    end

    // Per-block header flag and per-stream tree validity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            final_r     <= 1'b0;
            trees_valid <= 1'b0;
        end else begin
            if (hdr_pop) begin
                final_r <= hdr_final(rdata);
            end
            if (start_acc) begin
                trees_valid <= 1'b0;
            end else if (cl_done) begin
                trees_valid <= 1'b1;
            end
        end
    end

    // Saturating count of completed blocks in the current stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (start_acc) begin
            blk_cnt <= '0;
        end else if (dec_done && (blk_cnt != '1)) begin
            blk_cnt <= blk_cnt + BLKW'(1);
        end
    end

endmodule

// File: tb/tb_dcu_seq.sv
// Directed testbench for dcu_seq with hand-computed expectations.
module tb_dcu_seq;

    localparam int unsigned TO = 8;
    localparam int unsigned BW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          rempty;
    logic [3:0]    rdata;
    logic          fifo_rinc;
    logic          cl_rst_n;
    logic          cl_enb;
    logic          cl_rempty;
    logic          cl_rinc;
    logic          cl_fin;
    logic          tree_load;
    logic          dec_enb;
    logic          dec_rempty;
    logic          dec_rinc;
    logic          dec_eob;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [BW-1:0] blk_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    int bad_pop  = 0;
    int tl_cnt   = 0;
    int clr_cnt  = 0;
    int base;
    int base_clr;

    dcu_seq #(
        .TIMEOUT (TO),
        .BLKW    (BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rempty     (rempty),
        .rdata      (rdata),
        .fifo_rinc  (fifo_rinc),
        .cl_rst_n   (cl_rst_n),
        .cl_enb     (cl_enb),
        .cl_rempty  (cl_rempty),
        .cl_rinc    (cl_rinc),
        .cl_fin     (cl_fin),
        .tree_load  (tree_load),
        .dec_enb    (dec_enb),
        .dec_rempty (dec_rempty),
        .dec_rinc   (dec_rinc),
        .dec_eob    (dec_eob),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .blk_cnt    (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge monitor: pops, illegal pops, tree_load pulses, CL-out-of-reset cycles
    always @(posedge clk) begin
        if (fifo_rinc) pops++;
        if (fifo_rinc && rempty) bad_pop++;
        if (tree_load) tl_cnt++;
        if (cl_rst_n) clr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_hdr(input logic [3:0] h);
        rdata  = h;
        rempty = 1'b0;
        cyc();
    endtask

    task automatic do_cl(input int n);
        rempty = 1'b0;
        for (int i = 0; i < n; i++) begin
            cl_rinc = 1'b1;
            rdata   = 4'(i);
            cyc();
        end
        cl_rinc = 1'b0;
        cl_fin  = 1'b1;
        cyc();
        cl_fin  = 1'b0;
    endtask

    task automatic do_dec(input int n);
        rempty = 1'b0;
        for (int i = 0; i < n; i++) begin
            dec_rinc = 1'b1;
            rdata    = 4'(i);
            cyc();
        end
        dec_rinc = 1'b0;
        dec_eob  = 1'b1;
        cyc();
        dec_eob  = 1'b0;
        rempty   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; rempty = 1'b1; rdata = 4'h0;
        cl_rinc = 1'b0; cl_fin = 1'b0; dec_rinc = 1'b0; dec_eob = 1'b0;
        repeat (2) cyc();

        // Reset state
        check("rst_busy",       32'(busy), 0);
        check("rst_done",       32'(done), 0);
        check("rst_err",        32'(err), 0);
        check("rst_err_code",   32'(err_code), 0);
        check("rst_blk_cnt",    32'(blk_cnt), 0);
        check("rst_cl_rst_n",   32'(cl_rst_n), 0);
        check("rst_tree_load",  32'(tree_load), 0);
        check("rst_fifo_rinc",  32'(fifo_rinc), 0);
        check("rst_cl_enb",     32'(cl_enb), 0);
        check("rst_dec_enb",    32'(dec_enb), 0);
        check("rst_cl_rempty",  32'(cl_rempty), 1);
        check("rst_dec_rempty", 32'(dec_rempty), 1);
        rst_n = 1'b1;
        cyc();

        // Single dynamic block: 1 header + 45 CL + 20 decoder pops
        base = pops;
        do_start();
        check("t1_busy",       32'(busy), 1);
        check("t1_hdr_starve", 32'(fifo_rinc), 0);
        do_hdr(4'b1000);
        check("t1_cl_rst_n",   32'(cl_rst_n), 1);
        check("t1_cl_enb",     32'(cl_enb), 1);
        check("t1_cl_rempty",  32'(cl_rempty), 0);
        do_cl(45);
        check("t1_tree_load",  32'(tree_load), 1);
        check("t1_cl_rst_off", 32'(cl_rst_n), 0);
        check("t1_dec_enb",    32'(dec_enb), 1);
        check("t1_cl_enb_off", 32'(cl_enb), 0);
        check("t1_dec_rempty", 32'(dec_rempty), 0);
        do_dec(20);
        check("t1_done",       32'(done), 1);
        check("t1_busy_off",   32'(busy), 0);
        check("t1_blk_cnt",    32'(blk_cnt), 1);
        check("t1_pops",       32'(pops - base), 66);
        check("t1_tl_pulses",  32'(tl_cnt), 1);

        // Two blocks, second reuses trees
        base = pops;
        do_start();
        do_hdr(4'b0000);
        do_cl(3);
        do_dec(2);
        check("t2_busy_mid",   32'(busy), 1);
        check("t2_done_mid",   32'(done), 0);
        check("t2_blk_mid",    32'(blk_cnt), 1);
        base_clr = clr_cnt;
        do_hdr(4'b1001);
        check("t2_dec_enb",    32'(dec_enb), 1);
        check("t2_cl_rst_n",   32'(cl_rst_n), 0);
        do_dec(2);
        check("t2_done",       32'(done), 1);
        check("t2_blk_cnt",    32'(blk_cnt), 2);
        check("t2_cl_stay_rst", 32'(clr_cnt - base_clr), 0);
        check("t2_pops",       32'(pops - base), 9);

        // Reuse as first block
        base = pops;
        do_start();
        do_hdr(4'b0001);
        rempty = 1'b1;
        check("t3_err",        32'(err), 1);
        check("t3_err_code",   32'(err_code), 2);
        check("t3_busy",       32'(busy), 0);
        check("t3_pops",       32'(pops - base), 1);

        // Illegal mode, then restart from ERR
        base = pops;
        do_start();
        do_hdr(4'b0010);
        rempty = 1'b1;
        check("t4_err",        32'(err), 1);
        check("t4_err_code",   32'(err_code), 1);
        do_start();
        check("t4_err_clr",    32'(err), 0);
        check("t4_busy",       32'(busy), 1);
        check("t4_code_clr",   32'(err_code), 0);
        repeat (5) cyc();
        check("t4_hdr_wait",   32'(busy), 1);
        check("t4_pops",       32'(pops - base), 1);

        // Timeout: starvation does not count, stalls with data do
        do_hdr(4'b0000);
        rempty  = 1'b1;
        cl_rinc = 1'b1;
        repeat (100) cyc();
        check("t5_starve_err", 32'(err), 0);
        check("t5_cl_enb",     32'(cl_enb), 1);
        check("t5_cl_rempty",  32'(cl_rempty), 1);
        check("t5_rinc_gate",  32'(fifo_rinc), 0);
        cl_rinc = 1'b0;
        rempty  = 1'b0;
        repeat (TO - 1) cyc();
        check("t5_err_early",  32'(err), 0);
        cyc();
        check("t5_err",        32'(err), 1);
        check("t5_err_code",   32'(err_code), 3);
        check("t5_cl_rst_n",   32'(cl_rst_n), 0);
        rempty = 1'b1;

        // cl_fin / dec_eob coinciding with the timeout cycle
        do_start();
        do_hdr(4'b0000);
        repeat (TO - 1) cyc();
        cl_fin = 1'b1;
        cyc();
        cl_fin = 1'b0;
        check("t6_fin_wins",   32'(err), 0);
        check("t6_tree_load",  32'(tree_load), 1);
        repeat (TO - 1) cyc();
        dec_eob = 1'b1;
        cyc();
        dec_eob = 1'b0;
        rempty  = 1'b1;
        check("t6_eob_wins",   32'(err), 0);
        check("t6_busy",       32'(busy), 1);
        check("t6_blk_cnt",    32'(blk_cnt), 1);

        // start ignored while busy; blk_cnt saturates at BW bits
        do_hdr(4'b0001);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t7_start_ign",  32'(dec_enb), 1);
        check("t7_blk_keep",   32'(blk_cnt), 1);
        do_dec(1);
        do_hdr(4'b0101);
        do_dec(0);
        check("t7_blk3",       32'(blk_cnt), 3);
        do_hdr(4'b1001);
        do_dec(1);
        check("t7_blk_sat",    32'(blk_cnt), 3);
        check("t7_done",       32'(done), 1);

        // Asynchronous reset in DEC_RUN
        do_start();
        do_hdr(4'b0000);
        do_cl(2);
        dec_rinc = 1'b1;
        rempty   = 1'b0;
        cyc();
        #3 rst_n = 1'b0;
        #1;
        check("t8_fifo_rinc",  32'(fifo_rinc), 0);
        check("t8_dec_enb",    32'(dec_enb), 0);
        check("t8_busy",       32'(busy), 0);
        check("t8_cl_rst_n",   32'(cl_rst_n), 0);
        check("t8_done",       32'(done), 0);
        check("t8_err",        32'(err), 0);
        base = pops;
        repeat (3) cyc();
        check("t8_no_pops",    32'(pops - base), 0);
        dec_rinc = 1'b0;
        rempty   = 1'b1;
        rst_n    = 1'b1;
        cyc();
        do_start();
        check("t8_restart",    32'(busy), 1);
        check("t8_hdr_noenb",  32'(cl_enb | dec_enb), 0);
        do_hdr(4'b1000);
        check("t8_cl_rst_n1",  32'(cl_rst_n), 1);
        do_cl(0);
        do_dec(0);
        check("t8_done_end",   32'(done), 1);
        check("t8_blk_cnt",    32'(blk_cnt), 1);

        check("no_empty_pops", 32'(bad_pop), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
